mc_control_unit: RTL and testbench

Multi-cycle successor to the single-cycle control path. An FSM sequences each RV32I instruction through FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes (PC, IR, register-file, ALU source, memory). It handles variable-latency instruction and data memory via req/ready handshakes. It sits between the instruction register/decoder and the PC, RegFile, ALU and DataMem blocks.

---
 rtl/mc_control_unit_pkg.sv | 53 +++++
 rtl/mc_control_unit_if.sv | 46 ++++
 rtl/mc_control_unit_opcode_class.sv | 30 +++
 rtl/mc_control_unit.sv | 185 ++++++++++++++++++
 tb/tb_mc_control_unit.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_control_unit_pkg.sv
// Shared types for the multi-cycle control unit: FSM states, RV32I major opcodes,
// PC/write-back select encodings, trap causes and the instruction-class record.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_SRC_IMM   = 2'd1;
  localparam logic [1:0] PC_SRC_ALU   = 2'd2;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MDR = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_SYSTEM  = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  typedef struct packed {
    logic lui;
    logic auipc;
    logic jal;
    logic jalr;
    logic branch;
    logic load;
    logic store;
    logic op_imm;
    logic op;
    logic fence;
    logic system;
  } instr_class_t;

endpackage

// File: rtl/mc_control_unit_if.sv
// Control-unit <-> datapath/memory signal bundle. master = control unit, slave = datapath side.
// PERF_CNT_EN adds the cycle_cnt/instret counter outputs.
interface mc_control_unit_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       sys_imm12;
  logic       branch_cond;
  logic       imem_ready;
  logic       dmem_ready;
  logic       imem_req;
  logic       dmem_req;
  logic       dmem_we;
  logic [2:0] dmem_funct;
  logic       ir_we;
  logic       mdr_we;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       alu_src_imm;
  logic       rf_we;
  logic [1:0] wb_sel;
  logic       retire;
  logic       halted;
  logic [1:0] trap_cause;
`ifdef PERF_CNT_EN
  logic [63:0] cycle_cnt;
  logic [63:0] instret;
`endif

  modport master (
    input  opcode, funct3, sys_imm12, branch_cond, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we, dmem_funct, ir_we, mdr_we, pc_we, pc_src,
           alu_src_imm, rf_we, wb_sel, retire, halted, trap_cause
`ifdef PERF_CNT_EN
    , output cycle_cnt, instret
`endif
  );

  modport slave (
    output opcode, funct3, sys_imm12, branch_cond, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we, dmem_funct, ir_we, mdr_we, pc_we, pc_src,
           alu_src_imm, rf_we, wb_sel, retire, halted, trap_cause
`ifdef PERF_CNT_EN
    , input cycle_cnt, instret
`endif
  );
endinterface

// File: rtl/mc_control_unit_opcode_class.sv
// Combinational RV32I major-opcode classifier: one-hot class plus illegal flag.
module mc_opcode_class
  import mc_ctrl_pkg::*;
(
  input  logic [6:0]   i_opcode,
  output instr_class_t o_class,
  output logic         o_illegal
);

  always_comb begin
    o_class = '0;
    case (i_opcode)
      OPC_LUI:    o_class.lui    = 1'b1;
      OPC_AUIPC:  o_class.auipc  = 1'b1;
      OPC_JAL:    o_class.jal    = 1'b1;
      OPC_JALR:   o_class.jalr   = 1'b1;
      OPC_BRANCH: o_class.branch = 1'b1;
      OPC_LOAD:   o_class.load   = 1'b1;
      OPC_STORE:  o_class.store  = 1'b1;
      OPC_OP_IMM: o_class.op_imm = 1'b1;
      OPC_OP:     o_class.op     = 1'b1;
      OPC_FENCE:  o_class.fence  = 1'b1;
      OPC_SYSTEM: o_class.system = 1'b1;
      default:    o_class        = '0;
    endcase
  end

  assign o_illegal = (o_class == '0);

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with memory-wait timeout.
// Optional PERF_CNT_EN macro adds 64-bit cycle and retired-instruction counters.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input logic              clk,
  input logic              reset,
  mc_control_unit_if.master io_ctrl
);

  // The wait counter only has to reach MEM_TIMEOUT-1; it never needs to be wider than the datapath.
  localparam int WAIT_W_RAW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int WAIT_W     = (WAIT_W_RAW < XLEN) ? WAIT_W_RAW : XLEN;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e            r_state;
  state_e            w_state_next;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_next;
  logic [1:0]        r_cause;
  logic [1:0]        w_cause_next;
  logic              w_waiting;
  instr_class_t      w_class;
  logic              w_illegal;
  logic              w_unused_ok;

  assign w_unused_ok = io_ctrl.sys_imm12;

  mc_opcode_class u_opcode_class (
    .i_opcode  (io_ctrl.opcode),
    .o_class   (w_class),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_wait  <= '0;
      r_cause <= CAUSE_NONE;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_next;
      r_cause <= w_cause_next;
    end
  end

  always_comb begin
    w_state_next        = r_state;
    w_wait_next         = '0;
    w_cause_next        = r_cause;
    w_waiting           = 1'b0;
    io_ctrl.imem_req    = 1'b0;
    io_ctrl.dmem_req    = 1'b0;
    io_ctrl.dmem_we     = 1'b0;
    io_ctrl.dmem_funct  = 3'd0;
    io_ctrl.ir_we       = 1'b0;
    io_ctrl.mdr_we      = 1'b0;
    io_ctrl.pc_we       = 1'b0;
    io_ctrl.pc_src      = PC_SRC_PLUS4;
    io_ctrl.alu_src_imm = 1'b0;
    io_ctrl.rf_we       = 1'b0;
    io_ctrl.wb_sel      = WB_SEL_ALU;
    io_ctrl.retire      = 1'b0;
    io_ctrl.halted      = 1'b0;
    io_ctrl.trap_cause  = r_cause;

    unique case (r_state)
      FETCH: begin
        io_ctrl.imem_req = 1'b1;
        if (io_ctrl.imem_ready) begin
          io_ctrl.ir_we = 1'b1;
          w_state_next  = DECODE;
        end else begin
          w_waiting = 1'b1;
        end
      end
      DECODE: begin
        if (w_illegal) begin
          w_state_next = TRAP;
          w_cause_next = CAUSE_ILLEGAL;
        end else if (w_class.system) begin
          w_state_next = TRAP;
          w_cause_next = CAUSE_SYSTEM;
        end else begin
          w_state_next = EXEC;
        end
      end
      EXEC: begin
        io_ctrl.alu_src_imm = w_class.op_imm | w_class.load | w_class.store |
                              w_class.jalr | w_class.lui | w_class.auipc;
        if (w_class.branch || w_class.fence) begin
          io_ctrl.pc_we  = 1'b1;
          io_ctrl.pc_src = (w_class.branch && io_ctrl.branch_cond) ? PC_SRC_IMM : PC_SRC_PLUS4;
          io_ctrl.retire = 1'b1;
          w_state_next   = FETCH;
        end else if (w_class.load || w_class.store) begin
          w_state_next = MEM;
        end else begin
          w_state_next = WB;
        end
      end
      MEM: begin
        io_ctrl.dmem_req   = 1'b1;
        io_ctrl.dmem_we    = w_class.store;
        io_ctrl.dmem_funct = io_ctrl.funct3;
        if (io_ctrl.dmem_ready) begin
          if (w_class.store) begin
            io_ctrl.pc_we  = 1'b1;
            io_ctrl.retire = 1'b1;
            w_state_next   = FETCH;
          end else begin
            io_ctrl.mdr_we = 1'b1;
            w_state_next   = WB;
          end
        end else begin
          w_waiting = 1'b1;
        end
      end
      WB: begin
        io_ctrl.rf_we  = 1'b1;
        io_ctrl.wb_sel = w_class.load ? WB_SEL_MDR :
                         (w_class.jal || w_class.jalr) ? WB_SEL_PC4 : WB_SEL_ALU;
        io_ctrl.pc_we  = 1'b1;
        io_ctrl.pc_src = w_class.jal ? PC_SRC_IMM : w_class.jalr ? PC_SRC_ALU : PC_SRC_PLUS4;
        io_ctrl.retire = 1'b1;
        w_state_next   = FETCH;
      end
      TRAP: begin
        io_ctrl.halted = 1'b1;
      end
      default: begin
        w_state_next = FETCH;
      end
    endcase

    // A ready in the final allowed cycle takes the normal path because w_waiting is then low.
    if (w_waiting && (MEM_TIMEOUT > 0)) begin
      if (r_wait == WAIT_LAST) begin
        w_state_next = TRAP;
        w_cause_next = CAUSE_TIMEOUT;
      end else begin
        w_wait_next = r_wait + 1'b1;
      end
    end

    if (reset) begin
      io_ctrl.imem_req    = 1'b0;
      io_ctrl.dmem_req    = 1'b0;
      io_ctrl.dmem_we     = 1'b0;
      io_ctrl.dmem_funct  = 3'd0;
      io_ctrl.ir_we       = 1'b0;
      io_ctrl.mdr_we      = 1'b0;
      io_ctrl.pc_we       = 1'b0;
      io_ctrl.pc_src      = 2'd0;
      io_ctrl.alu_src_imm = 1'b0;
      io_ctrl.rf_we       = 1'b0;
      io_ctrl.wb_sel      = 2'd0;
      io_ctrl.retire      = 1'b0;
      io_ctrl.halted      = 1'b0;
      io_ctrl.trap_cause  = 2'd0;
    end
  end

`ifdef PERF_CNT_EN
  logic [63:0] r_cycle_cnt;
  logic [63:0] r_instret;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt <= '0;
      r_instret   <= '0;
    end else begin
      if (r_state != TRAP) r_cycle_cnt <= r_cycle_cnt + 64'd1;
      if (io_ctrl.retire)  r_instret   <= r_instret + 64'd1;
    end
  end

  assign io_ctrl.cycle_cnt = reset ? 64'd0 : r_cycle_cnt;
  assign io_ctrl.instret   = reset ? 64'd0 : r_instret;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: hand-written vector table, multi-cycle corner sequences,
// and randomized instructions checked against a per-instruction latency/strobe model.
`timescale 1ns/1ps
module tb_mc_control_unit;

  localparam int TMO    = 15;
  localparam int BUDGET = 60;
  localparam int NV     = 17;

  localparam logic [6:0] C_LUI    = 7'b0110111;
  localparam logic [6:0] C_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_JAL    = 7'b1101111;
  localparam logic [6:0] C_JALR   = 7'b1100111;
  localparam logic [6:0] C_BR     = 7'b1100011;
  localparam logic [6:0] C_LOAD   = 7'b0000011;
  localparam logic [6:0] C_STORE  = 7'b0100011;
  localparam logic [6:0] C_OPIMM  = 7'b0010011;
  localparam logic [6:0] C_OP     = 7'b0110011;
  localparam logic [6:0] C_FENCE  = 7'b0001111;
  localparam logic [6:0] C_SYS    = 7'b1110011;

  // Per-instruction observation: latency in cycles plus counts/values of each strobe.
  typedef struct {
    int lat;
    int ir_n;
    int alu_n;
    int rf_n;
    int wb_sel;
    int pc_we_n;
    int pc_src;
    int ret_n;
    int dmem_n;
    int dwe_n;
    int dfun_n;
    int mdr_n;
    int halted;
    int cause;
  } obs_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       bc;
    int         iw;
    int         dw;
    obs_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mc_control_unit_if bus();

  mc_control_unit #(.XLEN(32), .MEM_TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset   (reset),
    .io_ctrl (bus)
  );

  function automatic logic [18:0] all_outs();
    return {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.dmem_funct, bus.ir_we, bus.mdr_we,
            bus.pc_we, bus.pc_src, bus.alu_src_imm, bus.rf_we, bus.wb_sel, bus.retire,
            bus.halted, bus.trap_cause};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input obs_t o, input obs_t e);
    check({tag, ".latency"}, 64'(o.lat), 64'(e.lat));
    check({tag, ".ir_we"}, 64'(o.ir_n), 64'(e.ir_n));
    check({tag, ".alu_src_imm"}, 64'(o.alu_n), 64'(e.alu_n));
    check({tag, ".rf_we"}, 64'(o.rf_n), 64'(e.rf_n));
    check({tag, ".wb_sel"}, 64'(o.wb_sel), 64'(e.wb_sel));
    check({tag, ".pc_we"}, 64'(o.pc_we_n), 64'(e.pc_we_n));
    check({tag, ".pc_src"}, 64'(o.pc_src), 64'(e.pc_src));
    check({tag, ".retire"}, 64'(o.ret_n), 64'(e.ret_n));
    check({tag, ".dmem_req"}, 64'(o.dmem_n), 64'(e.dmem_n));
    check({tag, ".dmem_we"}, 64'(o.dwe_n), 64'(e.dwe_n));
    check({tag, ".dmem_funct"}, 64'(o.dfun_n), 64'(e.dfun_n));
    check({tag, ".mdr_we"}, 64'(o.mdr_n), 64'(e.mdr_n));
    check({tag, ".halted"}, 64'(o.halted), 64'(e.halted));
    check({tag, ".trap_cause"}, 64'(o.cause), 64'(e.cause));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    #1 check("reset_outputs_zero", 64'(all_outs()), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Runs one instruction from its first FETCH cycle until retire or halt; memories answer
  // after iw / dw not-ready cycles of their respective request.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic bc,
                           input int iw, input int dw, output obs_t o);
    int  icnt = 0;
    int  dcnt = 0;
    bit  done = 0;
    o = '{default: 0};
    o.lat = -1;
    for (int cyc = 1; cyc <= BUDGET && !done; cyc++) begin
      @(negedge clk);
      bus.opcode      = op;
      bus.funct3      = f3;
      bus.branch_cond = bc;
      bus.sys_imm12   = 1'($urandom_range(0, 1));
      if (bus.imem_req) begin
        bus.imem_ready = (icnt >= iw);
        icnt++;
      end else begin
        bus.imem_ready = 1'($urandom_range(0, 1));
      end
      if (bus.dmem_req) begin
        bus.dmem_ready = (dcnt >= dw);
        dcnt++;
      end else begin
        bus.dmem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (bus.ir_we) o.ir_n++;
      if (bus.alu_src_imm) o.alu_n++;
      if (bus.rf_we) begin
        o.rf_n++;
        o.wb_sel = int'(bus.wb_sel);
      end
      if (bus.dmem_req) o.dmem_n++;
      if (bus.dmem_we) o.dwe_n++;
      if (bus.dmem_req && bus.dmem_funct == f3) o.dfun_n++;
      if (bus.mdr_we) o.mdr_n++;
      if (bus.pc_we) o.pc_we_n++;
      if (bus.retire) begin
        o.ret_n++;
        o.pc_src = int'(bus.pc_src);
        o.lat = cyc;
        done = 1;
      end
      if (bus.halted) begin
        o.halted = 1;
        o.cause = int'(bus.trap_cause);
        o.lat = cyc;
        done = 1;
      end
    end
  endtask

  // Reference: expected strobes and latency derived from the instruction's class and wait counts.
  function automatic obs_t model(input logic [6:0] op, input logic bc, input int iw, input int dw);
    obs_t e = '{default: 0};
    bit legal = 1, sys = 0, ld = 0, st = 0, br = 0, fen = 0, jal = 0, jalr = 0, imm = 0;
    case (op)
      C_LUI, C_AUIPC, C_OPIMM: imm = 1;
      C_JAL:   jal = 1;
      C_JALR:  begin jalr = 1; imm = 1; end
      C_BR:    br = 1;
      C_LOAD:  begin ld = 1; imm = 1; end
      C_STORE: begin st = 1; imm = 1; end
      C_OP:    legal = 1;
      C_FENCE: fen = 1;
      C_SYS:   begin sys = 1; legal = 0; end
      default: legal = 0;
    endcase
    if (iw >= TMO) begin
      e.lat = TMO + 1; e.halted = 1; e.cause = 3;
      return e;
    end
    e.ir_n = 1;
    if (!legal) begin
      e.lat = iw + 3; e.halted = 1; e.cause = sys ? 2 : 1;
      return e;
    end
    e.alu_n = int'(imm);
    if (ld || st) begin
      if (dw >= TMO) begin
        e.lat = iw + TMO + 4; e.dmem_n = TMO; e.dwe_n = st ? TMO : 0; e.dfun_n = TMO;
        e.halted = 1; e.cause = 3;
        return e;
      end
      e.dmem_n = dw + 1; e.dwe_n = st ? dw + 1 : 0; e.dfun_n = dw + 1; e.mdr_n = int'(ld);
    end
    e.lat     = iw + ((br || fen) ? 3 : ld ? 5 + dw : st ? 4 + dw : 4);
    e.ret_n   = 1;
    e.pc_we_n = 1;
    e.pc_src  = br ? int'(bc) : jal ? 1 : jalr ? 2 : 0;
    e.rf_n    = (br || st || fen) ? 0 : 1;
    e.wb_sel  = (e.rf_n == 0) ? 0 : ld ? 1 : (jal || jalr) ? 2 : 0;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[NV];
    obs_t       o;
    obs_t       e;
    logic [6:0] pool[13];
    logic [6:0] op;
    logic [2:0] f3;
    logic       bc;
    int         iw, dw, ncnt, got_ret;

    bus.opcode = '0; bus.funct3 = '0; bus.sys_imm12 = 1'b0; bus.branch_cond = 1'b0;
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;

    //            name      op       f3    bc iw  dw   lat ir alu rf wb pcwe src ret dm dwe dfn mdr h c
    tbl[0]  = '{"add",     C_OP,    3'd0, 0, 0,  0, '{4,  1, 0, 1, 0, 1, 0, 1, 0,  0,  0,  0, 0, 0}};
    tbl[1]  = '{"lw_w3",   C_LOAD,  3'd2, 0, 0,  3, '{8,  1, 1, 1, 1, 1, 0, 1, 4,  0,  4,  1, 0, 0}};
    tbl[2]  = '{"beq_t",   C_BR,    3'd0, 1, 0,  0, '{3,  1, 0, 0, 0, 1, 1, 1, 0,  0,  0,  0, 0, 0}};
    tbl[3]  = '{"beq_nt",  C_BR,    3'd0, 0, 0,  0, '{3,  1, 0, 0, 0, 1, 0, 1, 0,  0,  0,  0, 0, 0}};
    tbl[4]  = '{"sw_w",    C_STORE, 3'd2, 0, 1,  2, '{7,  1, 1, 0, 0, 1, 0, 1, 3,  3,  3,  0, 0, 0}};
    tbl[5]  = '{"jal",     C_JAL,   3'd0, 0, 2,  0, '{6,  1, 0, 1, 2, 1, 1, 1, 0,  0,  0,  0, 0, 0}};
    tbl[6]  = '{"jalr",    C_JALR,  3'd0, 0, 0,  0, '{4,  1, 1, 1, 2, 1, 2, 1, 0,  0,  0,  0, 0, 0}};
    tbl[7]  = '{"lui",     C_LUI,   3'd0, 1, 0,  0, '{4,  1, 1, 1, 0, 1, 0, 1, 0,  0,  0,  0, 0, 0}};
    tbl[8]  = '{"auipc",   C_AUIPC, 3'd0, 0, 0,  0, '{4,  1, 1, 1, 0, 1, 0, 1, 0,  0,  0,  0, 0, 0}};
    tbl[9]  = '{"fence",   C_FENCE, 3'd0, 1, 0,  0, '{3,  1, 0, 0, 0, 1, 0, 1, 0,  0,  0,  0, 0, 0}};
    tbl[10] = '{"addi",    C_OPIMM, 3'd5, 0, 0,  0, '{4,  1, 1, 1, 0, 1, 0, 1, 0,  0,  0,  0, 0, 0}};
    tbl[11] = '{"ecall",   C_SYS,   3'd0, 0, 0,  0, '{3,  1, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 1, 2}};
    tbl[12] = '{"illegal", 7'h00,   3'd0, 0, 0,  0, '{3,  1, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 1, 1}};
    tbl[13] = '{"if_w14",  C_OP,    3'd0, 0, 14, 0, '{18, 1, 0, 1, 0, 1, 0, 1, 0,  0,  0,  0, 0, 0}};
    tbl[14] = '{"if_tmo",  C_OP,    3'd0, 0, 15, 0, '{16, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 1, 3}};
    tbl[15] = '{"lb_tmo",  C_LOAD,  3'd0, 0, 0, 15, '{19, 1, 1, 0, 0, 0, 0, 0, 15, 0, 15,  0, 1, 3}};
    tbl[16] = '{"sh_w14",  C_STORE, 3'd1, 0, 0, 14, '{18, 1, 1, 0, 0, 1, 0, 1, 15, 15, 15, 0, 0, 0}};

    do_reset();
    for (int i = 0; i < NV; i++) begin
      run_instr(tbl[i].op, tbl[i].f3, tbl[i].bc, tbl[i].iw, tbl[i].dw, o);
      $display("vec %-8s op=%b iw=%0d dw=%0d lat=%0d halted=%0d cause=%0d",
               tbl[i].name, tbl[i].op, tbl[i].iw, tbl[i].dw, o.lat, o.halted, o.cause);
      cmp(tbl[i].name, o, tbl[i].exp);
      if (tbl[i].exp.halted != 0) do_reset();
    end

    // Trap is sticky: illegal opcode, then 20 cycles with memories ready and a legal opcode.
    run_instr(7'h00, 3'd0, 1'b0, 0, 0, o);
    check("trap_hold.entry", 64'(o.cause), 64'd1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus.opcode = C_OP; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
      #1 check($sformatf("trap_hold.c%0d", k),
               64'({bus.halted, bus.trap_cause, bus.imem_req, bus.retire, bus.pc_we, bus.rf_we}),
               64'({1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0}));
    end
    do_reset();
    @(negedge clk);
    bus.imem_ready = 1'b0;
    #1 check("post_trap_reset", 64'({bus.imem_req, bus.halted, bus.trap_cause}), 64'({1'b1, 1'b0, 2'd0}));
    $display("seq trap_hold done");

    // Store aborted by reset during its second MEM wait cycle.
    do_reset();
    ncnt = 0;
    got_ret = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      bus.opcode = C_STORE; bus.funct3 = 3'd2; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0;
      if (bus.dmem_req) ncnt++;
      if (ncnt == 2) begin
        reset = 1'b1;
        #1 check("sw_abort.gated", 64'({bus.dmem_req, bus.dmem_we, bus.retire}), 64'd0);
        break;
      end
      #1 if (bus.retire) got_ret++;
    end
    check("sw_abort.reached_mem", 64'(ncnt), 64'd2);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #1 if (bus.retire) got_ret++;
    check("sw_abort.refetch", 64'({bus.imem_req, bus.dmem_req, bus.halted}), 64'({1'b1, 1'b0, 1'b0}));
    check("sw_abort.no_retire", 64'(got_ret), 64'd0);
    $display("seq sw_abort done");

    // Randomized instructions against the model.
    pool = '{C_LUI, C_AUIPC, C_JAL, C_JALR, C_BR, C_LOAD, C_STORE, C_OPIMM, C_OP, C_FENCE,
             C_SYS, 7'h00, 7'h7f};
    do_reset();
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : pool[$urandom_range(0, 12)];
      f3 = 3'($urandom);
      bc = 1'($urandom);
      iw = ($urandom_range(0, 11) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 4);
      dw = ($urandom_range(0, 5) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 4);
      e = model(op, bc, iw, dw);
      run_instr(op, f3, bc, iw, dw, o);
      $display("rnd %0d op=%b f3=%0d bc=%0d iw=%0d dw=%0d lat=%0d halted=%0d cause=%0d",
               n, op, f3, bc, iw, dw, o.lat, o.halted, o.cause);
      cmp($sformatf("rnd%0d", n), o, e);
      if (e.halted != 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
